// File: rtl/rv32i_types.sv
// Shared core types.
// Purpose: word/cacheline typedefs plus the state and operation enums used by
//          the round-robin memory arbiter.
// Contents: rv32i_word, llc_cacheline, arb_state_t, mem_op_t.
package rv32i_types;

  typedef logic [31:0]  rv32i_word;
  typedef logic [255:0] llc_cacheline;

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    FIN
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_t;

endpackage

// File: rtl/mem_arbiter_rr_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Purpose: find the first eligible requester after 'last', wrapping modulo
//          NUM_PORTS. Ports set in 'mask' are never selected.
// Ports:
//   req   in  [NUM_PORTS]  request vector
//   last  in  [IDX_W]      index granted most recently (search starts at last+1)
//   mask  in  [NUM_PORTS]  ports excluded from this search
//   valid out 1            an eligible requester was found
//   idx   out [IDX_W]      index of the winner (0 when valid is low)
module rr_pick #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  input  logic [NUM_PORTS-1:0] mask,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  logic [NUM_PORTS-1:0] elig;

  assign elig = req & ~mask;

  // Offsets 1..NUM_PORTS visit every port once, ending on 'last' itself, so a
  // sole requester that was granted last time still wins.
  always_comb begin
    int c;
    c     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      c = (int'(last) + i) % NUM_PORTS;
      if (!valid && elig[c[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter of NUM_PORTS cacheline clients onto one
// main-memory/LLC port.
// Purpose: grant one client at a time, latch its request, run it against
//          memory, return a one-cycle completion pulse and a registered line.
// Ports:
//   clk, rst (async, active-low)
//   port_read/port_write [NUM_PORTS]       per-client requests (both = write)
//   port_address [NUM_PORTS][ADDR_WIDTH]   per-client line address
//   port_wdata   [NUM_PORTS][LINE_WIDTH]   per-client write line
//   port_rdata   [LINE_WIDTH]              shared read line, valid with port_resp
//   port_resp    [NUM_PORTS]               one-cycle completion pulse, one-hot
//   mmem_read/mmem_write                   memory strobes (MEM state only)
//   mmem_address/mmem_wdata                latched request fields
//   mmem_rdata/mmem_resp                   memory return path
//   grant_id                               current or last granted port
module mem_arbiter_rr
  import rv32i_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  port_read,
  input  logic [NUM_PORTS-1:0]                  port_write,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  port_address,
  input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]  port_wdata,
  output logic [LINE_WIDTH-1:0]                 port_rdata,
  output logic [NUM_PORTS-1:0]                  port_resp,
  output logic                                  mmem_read,
  output logic                                  mmem_write,
  output logic [ADDR_WIDTH-1:0]                 mmem_address,
  output logic [LINE_WIDTH-1:0]                 mmem_wdata,
  input  logic [LINE_WIDTH-1:0]                 mmem_rdata,
  input  logic                                  mmem_resp,
  output logic [$clog2(NUM_PORTS)-1:0]          grant_id
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_t           state;
  mem_op_t              op_q;
  logic [IDX_W-1:0]     last_grant;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] pick_mask;
  logic [IDX_W-1:0]     pick_last;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic                 take;

  assign req = port_read | port_write;

  // In FIN the finishing client still drives its request, so it is masked and
  // the search resumes after it (last_grant is only being updated this cycle).
  assign pick_last = (state == FIN) ? grant_id : last_grant;
  assign pick_mask = (state == FIN) ? (NUM_PORTS'(1) << grant_id) : '0;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req   (req),
    .last  (pick_last),
    .mask  (pick_mask),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign take = pick_valid && (state == IDLE || state == FIN);

  // Strobes depend only on state and the latched op, so an asynchronous reset
  // drops them immediately.
  assign mmem_read  = (state == MEM) && (op_q == OP_READ);
  assign mmem_write = (state == MEM) && (op_q == OP_WRITE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant   <= IDX_W'(NUM_PORTS - 1);
      grant_id     <= '0;
      op_q         <= OP_READ;
      mmem_address <= '0;
      mmem_wdata   <= '0;
      port_rdata   <= '0;
      port_resp    <= '0;
    end else begin
      port_resp <= '0;
      unique case (state)
        IDLE: ;
        MEM: begin
          if (mmem_resp) begin
            port_rdata <= mmem_rdata;
            port_resp  <= NUM_PORTS'(1) << grant_id;
            state      <= FIN;
          end
        end
        FIN: begin
          last_grant <= grant_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A grant overrides the IDLE fallback above, giving back-to-back MEM.
      if (take) begin
        grant_id     <= pick_idx;
        op_q         <= port_write[pick_idx] ? OP_WRITE : OP_READ;
        mmem_address <= port_address[pick_idx];
        mmem_wdata   <= port_wdata[pick_idx];
        state        <= MEM;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;

  localparam int NP = 4;
  localparam int LW = 256;
  localparam int AW = 32;

  logic                   clk;
  logic                   rst;
  logic [NP-1:0]          port_read;
  logic [NP-1:0]          port_write;
  logic [NP-1:0][AW-1:0]  port_address;
  logic [NP-1:0][LW-1:0]  port_wdata;
  logic [LW-1:0]          port_rdata;
  logic [NP-1:0]          port_resp;
  logic                   mmem_read;
  logic                   mmem_write;
  logic [AW-1:0]          mmem_address;
  logic [LW-1:0]          mmem_wdata;
  logic [LW-1:0]          mmem_rdata;
  logic                   mmem_resp;
  logic [1:0]             grant_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t exp_q[$];

  mem_arbiter_rr #(
    .NUM_PORTS  (NP),
    .LINE_WIDTH (LW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .port_read    (port_read),
    .port_write   (port_write),
    .port_address (port_address),
    .port_wdata   (port_wdata),
    .port_rdata   (port_rdata),
    .port_resp    (port_resp),
    .mmem_read    (mmem_read),
    .mmem_write   (mmem_write),
    .mmem_address (mmem_address),
    .mmem_wdata   (mmem_wdata),
    .mmem_rdata   (mmem_rdata),
    .mmem_resp    (mmem_resp),
    .grant_id     (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [LW-1:0] pat(input logic [31:0] s);
    return {8{s}};
  endfunction

  task automatic drive(input int p, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    port_read[p]    = !wr;
    port_write[p]   = wr;
    port_address[p] = a;
    port_wdata[p]   = d;
  endtask

  task automatic expect_txn(input int p, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    txn_t t;
    t.port  = p;
    t.wr    = wr;
    t.addr  = a;
    t.wdata = d;
    exp_q.push_back(t);
  endtask

  // Wait for MEM, check against the scoreboard head, answer after 'lat' MEM
  // cycles, check the FIN pulse and that it lasts one cycle. 'drop' releases
  // the client request only after FIN has ended.
  task automatic serve(input int lat, input logic [LW-1:0] rd, input bit drop,
                       input bit perturb, output int waited);
    txn_t t;
    int   n;
    n = 0;
    while (!(mmem_read || mmem_write) && n < 20) begin
      tick();
      n++;
    end
    waited = n;
    chk("strobe_seen", 256'(mmem_read | mmem_write), 256'(1));
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL sb_nonempty observed %0d expected >0", exp_q.size());
    end
    if (exp_q.size() == 0) return;
    t = exp_q.pop_front();
    chk("grant_id", 256'(grant_id), 256'(t.port));
    chk("mmem_read", 256'(mmem_read), 256'(!t.wr));
    chk("mmem_write", 256'(mmem_write), 256'(t.wr));
    chk("mmem_address", 256'(mmem_address), 256'(t.addr));
    if (t.wr) chk("mmem_wdata", mmem_wdata, t.wdata);
    if (perturb) begin
      port_address[t.port] = ~t.addr;
      port_wdata[t.port]   = ~t.wdata;
      tick();
      chk("latched_address", 256'(mmem_address), 256'(t.addr));
      chk("latched_wdata", mmem_wdata, t.wdata);
      repeat (lat - 2) tick();
    end else begin
      repeat (lat - 1) tick();
    end
    mmem_resp  = 1'b1;
    mmem_rdata = rd;
    tick();
    mmem_resp  = 1'b0;
    chk("port_resp", 256'(port_resp), 256'(1) << t.port);
    if (!t.wr) chk("port_rdata", port_rdata, rd);
    chk("fin_strobes", 256'(mmem_read | mmem_write), 256'(0));
    tick();
    chk("resp_one_cycle", 256'(port_resp), 256'(0));
    if (drop) begin
      port_read[t.port]  = 1'b0;
      port_write[t.port] = 1'b0;
    end
  endtask

  initial begin
    int w;
    rst          = 1'b1;
    port_read    = '0;
    port_write   = '0;
    port_address = '0;
    port_wdata   = '0;
    mmem_rdata   = '0;
    mmem_resp    = 1'b0;

    // Reset values
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant_id", 256'(grant_id), 256'(0));
    chk("rst_strobes", 256'({mmem_read, mmem_write}), 256'(0));
    chk("rst_port_resp", 256'(port_resp), 256'(0));
    chk("rst_port_rdata", port_rdata, 256'(0));
    chk("rst_mmem_address", 256'(mmem_address), 256'(0));
    chk("rst_mmem_wdata", mmem_wdata, 256'(0));
    rst = 1'b1;
    tick();

    // Reset mid-MEM with port 1 write in flight
    drive(1, 1'b1, 32'h0000_2000, pat(32'hA5A5_0001));
    tick();
    chk("pre_rst_write", 256'(mmem_write), 256'(1));
    chk("pre_rst_grant", 256'(grant_id), 256'(1));
    #1 rst = 1'b0;
    #1;
    chk("async_rst_write", 256'(mmem_write), 256'(0));
    chk("async_rst_grant", 256'(grant_id), 256'(0));
    chk("async_rst_address", 256'(mmem_address), 256'(0));
    port_write[1] = 1'b0;
    #1 rst = 1'b1;
    repeat (2) begin
      tick();
      chk("abandoned_no_resp", 256'(port_resp), 256'(0));
      chk("abandoned_idle", 256'(mmem_read | mmem_write), 256'(0));
    end

    // All four ports requesting continuously: 0,1,2,3,0 with no idle cycles
    drive(0, 1'b0, 32'h0000_0100, pat(32'h1111_0000));
    drive(1, 1'b1, 32'h0000_0200, pat(32'h2222_0001));
    drive(2, 1'b0, 32'h0000_0300, pat(32'h3333_0002));
    drive(3, 1'b1, 32'h0000_0400, pat(32'h4444_0003));
    expect_txn(0, 1'b0, 32'h0000_0100, pat(32'h1111_0000));
    expect_txn(1, 1'b1, 32'h0000_0200, pat(32'h2222_0001));
    expect_txn(2, 1'b0, 32'h0000_0300, pat(32'h3333_0002));
    expect_txn(3, 1'b1, 32'h0000_0400, pat(32'h4444_0003));
    expect_txn(0, 1'b0, 32'h0000_0100, pat(32'h1111_0000));
    tick();
    serve(1, pat(32'hC0DE_0000), 1'b0, 1'b0, w);
    chk("rr_first_latency", 256'(w), 256'(0));
    serve(2, pat(32'hC0DE_0001), 1'b0, 1'b0, w);
    chk("rr_b2b_1", 256'(w), 256'(0));
    serve(1, pat(32'hC0DE_0002), 1'b0, 1'b0, w);
    chk("rr_b2b_2", 256'(w), 256'(0));
    serve(3, pat(32'hC0DE_0003), 1'b0, 1'b0, w);
    chk("rr_b2b_3", 256'(w), 256'(0));
    port_read[1]  = 1'b0; port_write[1] = 1'b0;
    port_read[2]  = 1'b0; port_write[2] = 1'b0;
    port_read[3]  = 1'b0; port_write[3] = 1'b0;
    serve(1, pat(32'hC0DE_0004), 1'b1, 1'b0, w);
    chk("rr_b2b_wrap", 256'(w), 256'(0));
    chk("rr_back_to_idle", 256'(mmem_read | mmem_write), 256'(0));

    // Single read: port 0, memory answers in the third MEM cycle
    drive(0, 1'b0, 32'h0000_1000, '0);
    expect_txn(0, 1'b0, 32'h0000_1000, '0);
    tick();
    serve(3, pat(32'hDEAD_BEEF), 1'b1, 1'b0, w);
    chk("single_latency", 256'(w), 256'(0));

    // Stray mmem_resp in IDLE is ignored and the line register holds
    mmem_resp  = 1'b1;
    mmem_rdata = pat(32'hBAD0_BAD0);
    tick();
    mmem_resp  = 1'b0;
    chk("stray_resp_pulse", 256'(port_resp), 256'(0));
    chk("stray_resp_rdata", port_rdata, pat(32'hDEAD_BEEF));
    chk("stray_resp_strobes", 256'(mmem_read | mmem_write), 256'(0));

    // Latching: port 2 changes its inputs during MEM
    drive(2, 1'b1, 32'h0000_3000, pat(32'h5A5A_0002));
    expect_txn(2, 1'b1, 32'h0000_3000, pat(32'h5A5A_0002));
    tick();
    serve(4, pat(32'h0), 1'b1, 1'b1, w);

    // Held request: port 1 holds through FIN, port 3 is next, port 1 not re-served
    drive(1, 1'b0, 32'h0000_4000, '0);
    expect_txn(1, 1'b0, 32'h0000_4000, '0);
    tick();
    drive(3, 1'b1, 32'h0000_5000, pat(32'h7777_0003));
    expect_txn(3, 1'b1, 32'h0000_5000, pat(32'h7777_0003));
    serve(2, pat(32'h9999_0001), 1'b1, 1'b0, w);
    serve(2, pat(32'h0), 1'b1, 1'b0, w);
    chk("held_b2b", 256'(w), 256'(0));
    repeat (3) begin
      chk("held_no_reserve", 256'(mmem_read | mmem_write), 256'(0));
      chk("held_no_resp", 256'(port_resp), 256'(0));
      tick();
    end
    chk("sb_drained", 256'(exp_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised round-robin arbiter that multiplexes NUM_PORTS cacheline-granular clients (I-cache, D-cache, prefetcher, …) onto the single main-memory/LLC port. Successor to the fixed two-port I/D arbiter. Adds:

- N clients with fair round-robin priority instead of fixed I-over-D priority.
- Latching of the granted request (address, op, write data).
- A registered read-data line.
- Back-to-back grants without an idle cycle.

## Interface

Parameters:

- NUM_PORTS, 2, number of clients (≥2); port 0 wins first after reset.
- LINE_WIDTH, 256, cacheline width in bits.
- ADDR_WIDTH, 32, address width.

Ports (one clock; reset is asynchronous and active-low):

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- port_read  in  [NUM_PORTS]  per-client read request
- port_write  in  [NUM_PORTS]  per-client write request
- port_address  in  [NUM_PORTS][ADDR_WIDTH]  per-client line address
- port_wdata  in  [NUM_PORTS][LINE_WIDTH]  per-client write line
- port_rdata  out  LINE_WIDTH  read line, shared by all clients, valid with port_resp
- port_resp  out  [NUM_PORTS]  one-cycle completion pulse, one-hot or zero
- mmem_read  out  1  memory read strobe
- mmem_write  out  1  memory write strobe
- mmem_address  out  ADDR_WIDTH  memory address
- mmem_wdata  out  LINE_WIDTH  memory write line
- mmem_rdata  in  LINE_WIDTH  memory read line, valid with mmem_resp
- mmem_resp  in  1  memory completion
- grant_id  out  $clog2(NUM_PORTS)  index of the current or last granted port (debug)

## Operation

State machine: IDLE, MEM, FIN.

- **Request:** port p requests when port_read[p] | port_write[p]. If both are high, the request is a write (illegal from caches; defined for safety).
- **Arbitration:** search starts at last_grant+1 and wraps modulo NUM_PORTS. The first requester wins.
- **Grant (IDLE or FIN → MEM):**
  - Latch grant_id, op, port_address[grant] and port_wdata[grant].
  - Client inputs are ignored until FIN.
- **MEM:**
  - mmem_read/mmem_write = latched op (exactly one high).
  - mmem_address/mmem_wdata = latched values.
  - On mmem_resp: capture mmem_rdata into the line register and go to FIN.
- **FIN:**
  - port_resp[grant_id] = 1 for exactly one cycle.
  - last_grant ← grant_id.
  - Arbitrate in the same cycle with port grant_id masked, because that client still holds its request this cycle. Any other requester → MEM; otherwise → IDLE.
- **IDLE:** no request → stay.
- **Fairness:** a continuously requesting port is granted within NUM_PORTS grants.
- **Output register behaviour:**
  - port_rdata holds the last captured line until the next mmem_resp; contents are meaningful only for reads.
  - mmem_address/mmem_wdata hold their latched values outside MEM; only the strobes are gated.

## Timing

- Reset values: state=IDLE, last_grant=NUM_PORTS-1, grant_id=0, mmem_read=mmem_write=0, port_resp=0, port_rdata=0, mmem_address=0, mmem_wdata=0.
- Request seen at edge t → MEM at t+1, mmem_* strobes high from t+1.
- mmem_resp seen at edge k → port_resp and valid port_rdata during cycle k+1.
- Minimum request-to-resp latency: 2 cycles (memory responding in the first MEM cycle).
- Back-to-back: the FIN cycle is also the arbitration cycle, so another port's MEM follows directly. Per-transfer overhead is 1 cycle.
- The same port re-requesting passes through IDLE: 1 extra cycle, if it is the sole requester.
- Strobes are driven from state and latched registers only, never combinationally from port inputs.
- mmem_resp outside MEM is ignored.
- Reset asserted mid-transfer:
  - Immediate return to reset values; strobes drop without waiting for a clock.
  - The in-flight transfer is abandoned and no port_resp is issued.

## Structure

- Use the existing rv32i_types package. Add to it:
  - arb_state_t enum {IDLE, MEM, FIN};
  - mem_op_t enum {OP_READ, OP_WRITE}.
- When LINE_WIDTH=256 and ADDR_WIDTH=32, port types are interchangeable with llc_cacheline and rv32i_word.
- Sub-module rr_pick (combinational): inputs req[NUM_PORTS], last[$clog2(NUM_PORTS)], mask[NUM_PORTS]; outputs valid, idx. Reusable by the later MSHR arbiter.
- Remaining logic in one module: FSM, latch registers, line register.

## Test plan

- Reset mid-MEM (port 1 write in flight): mmem_write drops asynchronously; no port_resp; after release, port 0 wins first.
- Single read, NUM_PORTS=2: port0 read addr 0x0000_1000 at t0 → mmem_read=1, address 0x1000 from t0+1; mmem_resp with 0xDEAD…BEEF at t0+3 → port_resp=2'b01 and port_rdata=0xDEAD…BEEF at t0+4, exactly one cycle.
- Simultaneous requests, NUM_PORTS=4, all ports requesting continuously: grant order 0,1,2,3,0,… with no IDLE cycles between transfers.
- Latching: port 2 changes port_address/port_wdata during MEM → mmem_address/mmem_wdata keep the values from the grant cycle.
- Held request: port 1 holds read through FIN while port 3 requests → next grant is port 3; port 1 is not re-served from the stale request.
